model_loader: RTL and testbench

//  Host-side writer for the accelerator's model memories. Accepts a 32-bit valid/ready

---
 rtl/model_loader_if.sv | 18 +
 rtl/model_loader.sv | 154 +++++++++++++++
 tb/tb_model_loader.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/model_loader_if.sv
// Host stream into the model loader: 32-bit words under a valid/ready handshake.
interface model_loader_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/model_loader.sv
// Model memory loader: packs 8 stream beats into 256-bit words and writes
// the clause memory first, then the class weight memory, then pulses load_done.
module model_loader #(
    parameter int unsigned CLAUSEN  = 10,
    parameter int unsigned CLASSN   = 10,
    parameter int unsigned WT_WORDS = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [8:0]    clauses,
    model_loader_if.slave stream,
    output logic [255:0]  clause_write,
    output logic          wea,
    output logic [31:0]   bram_addr_a,
    output logic [255:0]  weight_write,
    output logic          wea2,
    output logic [31:0]   bram_addr_a2,
    output logic          busy,
    output logic          load_done
);

    typedef enum logic [2:0] {
        IDLE,
        C_PACK,
        C_WR,
        W_PACK,
        W_WR,
        DONE
    } state_t;

    localparam logic [8:0]  CLAUSE_MAX = 9'(CLAUSEN);
    localparam logic [31:0] W_LAST     = 32'(CLASSN * WT_WORDS - 1);

    state_t       state;
    state_t       state_nxt;
    logic [2:0]   beat;
    logic [223:0] pack;
    logic [8:0]   n_lat;
    logic [8:0]   n_clamped;
    logic [31:0]  cidx;
    logic [31:0]  widx;
    logic         pack_state;
    logic         accept;
    logic         last_beat;
    logic         c_last;
    logic         w_last;

    assign n_clamped     = (clauses > CLAUSE_MAX) ? CLAUSE_MAX : clauses;
    assign pack_state    = (state == C_PACK) || (state == W_PACK);
    assign stream.s_ready = pack_state;
    assign accept        = stream.s_valid && pack_state;
    assign last_beat     = accept && (beat == 3'd7);
    assign c_last        = (cidx == (32'(n_lat) - 32'd1));
    assign w_last        = (widx == W_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state strobes
    always_comb begin
        state_nxt = state;
        wea       = 1'b0;
        wea2      = 1'b0;
        busy      = 1'b1;
        load_done = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (n_clamped != 9'd0) ? C_PACK : W_PACK;
                end
            end
            C_PACK: begin
                if (last_beat) begin
                    state_nxt = C_WR;
                end
            end
            C_WR: begin
                wea       = 1'b1;
                state_nxt = c_last ? W_PACK : C_PACK;
            end
            W_PACK: begin
                if (last_beat) begin
                    state_nxt = W_WR;
                end
            end
            W_WR: begin
                wea2      = 1'b1;
                state_nxt = w_last ? DONE : W_PACK;
            end
            DONE: begin
                load_done = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Beat packing, word/address output registers and word counters.
    // The 8th beat goes straight into the output word so the strobe can
    // follow on the very next cycle; beats 0..6 wait in the pack register.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat         <= '0;
            pack         <= '0;
            n_lat        <= '0;
            cidx         <= '0;
            widx         <= '0;
            clause_write <= '0;
            bram_addr_a  <= '0;
            weight_write <= '0;
            bram_addr_a2 <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                n_lat <= n_clamped;
                cidx  <= '0;
                widx  <= '0;
                beat  <= '0;
            end
            if (accept) begin
                beat <= beat + 3'd1;
                for (int unsigned k = 0; k < 7; k++) begin
                    if (beat == 3'(k)) begin
                        pack[k*32 +: 32] <= stream.s_data;
                    end
                end
                if (last_beat && (state == C_PACK)) begin
                    clause_write <= {stream.s_data, pack};
                    bram_addr_a  <= cidx;
                end
                if (last_beat && (state == W_PACK)) begin
                    weight_write <= {stream.s_data, pack};
                    bram_addr_a2 <= widx;
                end
            end
            if (state == C_WR) begin
                cidx <= cidx + 32'd1;
            end
            if (state == W_WR) begin
                widx <= widx + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_model_loader.sv
// Randomized self-checking bench for model_loader against a word-list model.
module tb_model_loader;

    localparam int unsigned CLAUSEN  = 10;
    localparam int unsigned CLASSN   = 10;
    localparam int unsigned WT_WORDS = 5;
    localparam int unsigned NW       = CLASSN * WT_WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [8:0]   clauses;
    logic [255:0] clause_write;
    logic         wea;
    logic [31:0]  bram_addr_a;
    logic [255:0] weight_write;
    logic         wea2;
    logic [31:0]  bram_addr_a2;
    logic         busy;
    logic         load_done;

    model_loader_if stream();

    model_loader #(
        .CLAUSEN  (CLAUSEN),
        .CLASSN   (CLASSN),
        .WT_WORDS (WT_WORDS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .clauses      (clauses),
        .stream       (stream.slave),
        .clause_write (clause_write),
        .wea          (wea),
        .bram_addr_a  (bram_addr_a),
        .weight_write (weight_write),
        .wea2         (wea2),
        .bram_addr_a2 (bram_addr_a2),
        .busy         (busy),
        .load_done    (load_done)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int unsigned  checks   = 0;
    int unsigned  failures = 0;

    logic [31:0]  beats[$];
    logic [255:0] c_words[$];
    logic [255:0] w_words[$];
    logic [31:0]  c_addrs[$];
    logic [31:0]  w_addrs[$];
    int unsigned  ptr;
    int unsigned  done_cnt;
    int unsigned  both_cnt;
    int unsigned  lat_err;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: note a handshake, then sample every DUT output 1ns after the edge.
    task automatic step();
        logic acc;
        logic word_end;
        acc = stream.s_valid && stream.s_ready;
        @(posedge clk);
        #1;
        if (acc) ptr++;
        word_end = acc && (ptr % 8 == 0);
        if (wea) begin
            c_words.push_back(clause_write);
            c_addrs.push_back(bram_addr_a);
        end
        if (wea2) begin
            w_words.push_back(weight_write);
            w_addrs.push_back(bram_addr_a2);
        end
        if (wea && wea2) both_cnt++;
        if ((wea || wea2) != word_end) lat_err++;
        if (load_done) done_cnt++;
    endtask

    task automatic clear_obs();
        c_words.delete();
        w_words.delete();
        c_addrs.delete();
        w_addrs.delete();
        ptr      = 0;
        done_cnt = 0;
        both_cnt = 0;
        lat_err  = 0;
    endtask

    // Reference: n clause words then NW weight words, each from 8 consecutive beats.
    task automatic build(input int unsigned cl, input bit idx_data, output int unsigned n);
        n = (cl > CLAUSEN) ? CLAUSEN : cl;
        beats.delete();
        for (int unsigned i = 0; i < 8 * (n + NW); i++) begin
            beats.push_back(idx_data ? 32'(i) : 32'($urandom));
        end
    endtask

    function automatic logic [255:0] exp_word(input int unsigned w);
        logic [255:0] r;
        for (int unsigned k = 0; k < 8; k++) r[32*k +: 32] = beats[8*w + k];
        return r;
    endfunction

    task automatic run_load(input string name, input int unsigned cl, input int unsigned vmode,
                            input bit idx_data, input int unsigned restart_at);
        int unsigned n;
        bit          fin;
        build(cl, idx_data, n);
        clear_obs();
        clauses        = 9'(cl);
        start          = 1'b1;
        stream.s_valid = 1'b1;
        stream.s_data  = beats[0];
        step();
        start = 1'b0;
        check({name, "_busy_on"}, 256'(busy), 256'(1));
        check({name, "_idle_noconsume"}, 256'(ptr), 256'(0));
        fin = 1'b0;
        for (int unsigned cyc = 0; cyc < 4000 && !fin; cyc++) begin
            if (ptr < beats.size()) begin
                case (vmode)
                    0:       stream.s_valid = 1'b1;
                    1:       stream.s_valid = (cyc % 2 == 0);
                    default: stream.s_valid = 1'($urandom_range(0, 1));
                endcase
                stream.s_data = beats[ptr];
            end else begin
                stream.s_valid = 1'b0;
                stream.s_data  = $urandom;
            end
            if (restart_at != 0 && cyc == restart_at) begin
                start   = 1'b1;
                clauses = 9'($urandom_range(1, 9));
            end else begin
                start = 1'b0;
            end
            step();
            if (load_done) begin
                check({name, "_busy_in_done"}, 256'(busy), 256'(1));
                fin = 1'b1;
            end
        end
        start = 1'b0;
        check({name, "_finished"}, 256'(fin), 256'(1));
        check({name, "_n_wea"}, 256'(c_words.size()), 256'(n));
        check({name, "_n_wea2"}, 256'(w_words.size()), 256'(NW));
        for (int unsigned i = 0; i < n && i < c_words.size(); i++) begin
            check($sformatf("%s_cword%0d", name, i), c_words[i], exp_word(i));
            check($sformatf("%s_caddr%0d", name, i), 256'(c_addrs[i]), 256'(i));
        end
        for (int unsigned j = 0; j < NW && j < w_words.size(); j++) begin
            check($sformatf("%s_wword%0d", name, j), w_words[j], exp_word(n + j));
            check($sformatf("%s_waddr%0d", name, j), 256'(w_addrs[j]), 256'(j));
        end
        // Idle afterwards: valid stream must not be consumed, no strobes.
        stream.s_valid = 1'b1;
        repeat (5) step();
        stream.s_valid = 1'b0;
        check({name, "_done_once"}, 256'(done_cnt), 256'(1));
        check({name, "_busy_off"}, 256'(busy), 256'(0));
        check({name, "_ready_off"}, 256'(stream.s_ready), 256'(0));
        check({name, "_no_extra_beats"}, 256'(ptr), 256'(beats.size()));
        check({name, "_no_extra_wea"}, 256'(c_words.size()), 256'(n));
        check({name, "_no_extra_wea2"}, 256'(w_words.size()), 256'(NW));
        check({name, "_no_overlap"}, 256'(both_cnt), 256'(0));
        check({name, "_latency"}, 256'(lat_err), 256'(0));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_wea"}, 256'(wea), 256'(0));
        check({name, "_wea2"}, 256'(wea2), 256'(0));
        check({name, "_ready"}, 256'(stream.s_ready), 256'(0));
        check({name, "_busy"}, 256'(busy), 256'(0));
        check({name, "_done"}, 256'(load_done), 256'(0));
        check({name, "_cword"}, clause_write, 256'(0));
        check({name, "_caddr"}, 256'(bram_addr_a), 256'(0));
        check({name, "_wword"}, weight_write, 256'(0));
        check({name, "_waddr"}, 256'(bram_addr_a2), 256'(0));
    endtask

    task automatic reset_mid();
        int unsigned n;
        build(2, 1'b1, n);
        clear_obs();
        clauses        = 9'd2;
        start          = 1'b1;
        stream.s_valid = 1'b1;
        stream.s_data  = beats[0];
        step();
        start = 1'b0;
        for (int unsigned cyc = 0; cyc < 200 && ptr < 11; cyc++) begin
            stream.s_valid = 1'b1;
            stream.s_data  = beats[ptr];
            step();
        end
        check("t5_reached_beat11", 256'(ptr), 256'(11));
        check("t5_one_word_before_rst", 256'(c_words.size()), 256'(1));
        stream.s_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("t5_after_rst");
        stream.s_valid = 1'b1;
        stream.s_data  = beats[ptr];
        repeat (20) step();
        stream.s_valid = 1'b0;
        check("t5_no_more_wea", 256'(c_words.size()), 256'(1));
        check("t5_no_more_wea2", 256'(w_words.size()), 256'(0));
        check("t5_not_consumed", 256'(ptr), 256'(11));
        check("t5_ready_low", 256'(stream.s_ready), 256'(0));
    endtask

    // Test sequence
    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        clauses        = '0;
        stream.s_valid = 1'b0;
        stream.s_data  = '0;
        clear_obs();
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        run_load("t1", 2, 0, 1'b1, 0);
        check("t1_word0", c_words[0], 256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);
        run_load("t2", 2, 1, 1'b1, 0);
        run_load("t3", 0, 2, 1'b0, 0);
        check("t3_addr_class3_off4", 256'(w_addrs[19]), 256'(3 * WT_WORDS + 4));
        run_load("t4", 300, 2, 1'b0, 0);
        reset_mid();
        run_load("t5_reload", 2, 2, 1'b0, 0);
        run_load("t6", 3, 2, 1'b0, 20);
        for (int unsigned r = 0; r < 3; r++) begin
            run_load($sformatf("rnd%0d", r), $urandom_range(0, 20), 2, 1'b0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
